// File: rtl/interrupt_timer_pkg.sv
// Shared definitions for the interrupt timer: FSM states, cause bit positions, default width.
package interrupt_timer_pkg;

    localparam int unsigned WIDTH_DEFAULT    = 32;
    localparam int unsigned CAUSE_TIMER_BIT  = 0;
    localparam int unsigned CAUSE_BUTTON_BIT = 1;
    localparam int unsigned CAUSE_BITS       = 2;

    typedef enum logic [1:0] {
        StIdle,
        StCounting,
        StPending,
        StServicing
    } timerState_e;

    function automatic logic [CAUSE_BITS-1:0] causeMask(input logic timerEvt,
                                                       input logic buttonEvt);
        logic [CAUSE_BITS-1:0] mask;
        mask                   = '0;
        mask[CAUSE_TIMER_BIT]  = timerEvt;
        mask[CAUSE_BUTTON_BIT] = buttonEvt;
        return mask;
    endfunction

endpackage

// File: rtl/interrupt_timer_if.sv
// Control-unit side of the interrupt timer: instruction strobes, operands and results.
interface interrupt_timer_if
    import interrupt_timer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic             setClock;
    logic [WIDTH-1:0] quantum_in;
    logic             savePCBuffer;
    logic             getInterruption;
    logic             EnableClock;
    logic [WIDTH-1:0] pc_in;
    logic             Button;
    logic             irq;
    logic [WIDTH-1:0] irq_cause;
    logic [WIDTH-1:0] pc_buffer;
    logic [WIDTH-1:0] count;

    modport master (
        output setClock, quantum_in, savePCBuffer, getInterruption, EnableClock, pc_in, Button,
        input  irq, irq_cause, pc_buffer, count
    );

    modport slave (
        input  setClock, quantum_in, savePCBuffer, getInterruption, EnableClock, pc_in, Button,
        output irq, irq_cause, pc_buffer, count
    );
endinterface

// File: rtl/interrupt_timer_button_sync.sv
// Two-flop synchroniser for the asynchronous button plus a rising-edge detector.
module button_sync (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic rise
);
    logic metaQ;
    logic stableQ;
    logic prevQ;

    always_ff @(posedge clock) begin
        if (!reset) begin
            metaQ   <= 1'b0;
            stableQ <= 1'b0;
            prevQ   <= 1'b0;
        end else begin
            metaQ   <= button;
            stableQ <= metaQ;
            prevQ   <= stableQ;
        end
    end

    // Left combinational so the cause bit lands on the third edge after the button rises.
    assign rise = stableQ & ~prevQ;

endmodule

// File: rtl/interrupt_timer.sv
// Quantum down-counter with button interrupt, cause register and saved return PC.
module interrupt_timer
    import interrupt_timer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input logic              clock,
    input logic              reset,
    interrupt_timer_if.slave bus
);
    timerState_e           stateQ, stateD;
    logic [WIDTH-1:0]      countQ, countD;
    logic [WIDTH-1:0]      pcBufferQ, pcBufferD;
    logic [CAUSE_BITS-1:0] causeQ, causeD;
    logic                  irqQ;
    logic                  buttonRise;
    logic                  timerEvt;

    button_sync uButtonSync (
        .clock  (clock),
        .reset  (reset),
        .button (bus.Button),
        .rise   (buttonRise)
    );

    always_comb begin
        stateD    = stateQ;
        countD    = countQ;
        pcBufferD = pcBufferQ;
        timerEvt  = 1'b0;
        causeD    = bus.getInterruption ? '0 : causeQ;

        if (bus.savePCBuffer) begin
            pcBufferD = bus.pc_in;
        end

        unique case (stateQ)
            StIdle, StCounting: begin
                if (bus.setClock) begin
                    // A reload or disarm pre-empts any expiry in the same cycle.
                    countD = bus.quantum_in;
                    stateD = (bus.quantum_in != '0) ? StCounting : StIdle;
                end else if (stateQ == StCounting && !buttonRise && bus.EnableClock &&
                             countQ != '0) begin
                    countD = countQ - WIDTH'(1);
                    if (countQ == WIDTH'(1)) begin
                        timerEvt = 1'b1;
                        stateD   = StPending;
                    end
                end
                if (buttonRise) begin
                    stateD = StPending;
                end
            end
            StPending: begin
                if (bus.savePCBuffer) begin
                    stateD = StServicing;
                end
            end
            StServicing: begin
                if (bus.setClock) begin
                    countD = bus.quantum_in;
                    stateD = (bus.quantum_in != '0) ? StCounting : StIdle;
                end
            end
            default: stateD = StIdle;
        endcase

        causeD = causeD | causeMask(timerEvt, buttonRise);

        // Leaving service with an unacknowledged cause goes straight back to pending.
        if (stateQ == StServicing && bus.setClock && causeD != '0) begin
            stateD = StPending;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stateQ    <= StIdle;
            countQ    <= '0;
            pcBufferQ <= '0;
            causeQ    <= '0;
            irqQ      <= 1'b0;
        end else begin
            stateQ    <= stateD;
            countQ    <= countD;
            pcBufferQ <= pcBufferD;
            causeQ    <= causeD;
            irqQ      <= (stateD == StPending);
        end
    end

    assign bus.irq       = irqQ;
    assign bus.irq_cause = WIDTH'(causeQ);
    assign bus.pc_buffer = pcBufferQ;
    assign bus.count     = countQ;

endmodule

// File: doc/interrupt_timer.md
INTERRUPT_TIMER -- requirements
Module: interrupt_timer

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of quantum, counter, PC and cause.
REQ-002 clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 setClock  in  1  decoded set-clock instruction strobe from the control unit; one cycle per instruction.
REQ-005 quantum_in  in  WIDTH  register operand carried with setClock; quantum in enabled cycles; 0 = disarm.
REQ-006 savePCBuffer  in  1  decoded save-PC-buffer strobe; captures pc_in.
REQ-007 getInterruption  in  1  decoded get-interruption strobe; read-and-clear of the cause register.
REQ-008 EnableClock  in  1  CPU advance enable; low during IN stall or halt.
REQ-009 pc_in  in  WIDTH  PC of the instruction executing this cycle.
REQ-010 Button  in  1  asynchronous external interrupt button, active-high.
REQ-011 irq  out  1  interrupt request to the PC-select logic; level, registered.
REQ-012 irq_cause  out  WIDTH  cause value for getInterruption write-back; combinational from the cause register.
REQ-013 pc_buffer  out  WIDTH  saved return PC.
REQ-014 count  out  WIDTH  current down-counter value.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, COUNTING, PENDING and SERVICING.
REQ-016 IDLE: setClock with quantum_in != 0 SHALL load count = quantum_in and enter COUNTING next cycle; quantum_in = 0 SHALL keep IDLE.
REQ-017 COUNTING: count SHALL decrement by 1 only in cycles with EnableClock = 1; it SHALL hold when EnableClock = 0.
REQ-018 COUNTING: a decrement from 1 to 0 SHALL set cause bit 0 (timer) and enter PENDING; irq SHALL be 1 on the following cycle.
REQ-019 COUNTING: setClock SHALL reload count (nonzero) or disarm to IDLE with count = 0 (zero); setClock SHALL win over a same-cycle expiry, with no cause set.
REQ-020 A synchronised Button rising edge SHALL set cause bit 1 in any state; in IDLE or COUNTING it SHALL also enter PENDING, freezing count.
REQ-021 PENDING: irq SHALL stay 1 until savePCBuffer; savePCBuffer SHALL latch pc_buffer = pc_in, enter SERVICING, and clear irq on the next cycle.
REQ-022 savePCBuffer outside PENDING SHALL still latch pc_buffer, with no state change.
REQ-023 SERVICING: no new PENDING entry; events only set cause bits; irq = 0.
REQ-024 SERVICING: setClock nonzero SHALL go to COUNTING with reload; setClock zero SHALL go to IDLE; if cause != 0 after that cycle, the FSM SHALL go to PENDING instead.
REQ-025 getInterruption: irq_cause SHALL equal the cause register in that cycle; the cause register SHALL clear on the next edge, except bits set by a same-cycle event, which SHALL remain set.
REQ-026 Cause bits above bit 1 SHALL read 0; count arithmetic is unsigned WIDTH, with no wrap below 0.

Reset
REQ-027 While reset = 0 at a clock edge: state = IDLE, count = 0, irq = 0, cause = 0, pc_buffer = 0, synchroniser flops = 0.
REQ-028 Reset mid-operation SHALL discard any pending interrupt and saved PC; the first edge after release SHALL behave as IDLE.

Structure
REQ-029 A shared package SHALL hold the state enum, CAUSE_TIMER_BIT = 0, CAUSE_BUTTON_BIT = 1 and WIDTH default.
REQ-030 Button synchronisation (2 flops plus rising-edge detect, 3-cycle latency to cause) SHALL be the sub-module button_sync.
REQ-031 Total RTL SHALL fit 120-400 lines; no latches, and all FSM outputs SHALL be registered except irq_cause.

Verification
REQ-032 setClock, quantum_in = 5, EnableClock = 1 -> count 5,4,3,2,1,0; irq = 1 on the cycle after count = 0; cause = 1.
REQ-033 quantum 3, EnableClock low for 4 cycles mid-count -> count holds; irq is delayed exactly 4 cycles.
REQ-034 PENDING, savePCBuffer with pc_in = 0x40 -> pc_buffer = 0x40; irq = 0 next cycle; state = SERVICING.
REQ-035 getInterruption with cause = 1 and Button edge reaching cause in the same cycle -> irq_cause = 1; next cause = 2.
REQ-036 COUNTING at count = 1, setClock quantum 0 in the same cycle -> IDLE, count = 0, irq never asserts, cause = 0.
REQ-037 reset = 0 during PENDING with pc_buffer = 0x40 -> next cycle irq = 0, cause = 0, pc_buffer = 0, state = IDLE.
